// File: rtl/xmit_phy_pkg.sv
// Shared types and constants for the transmit-side PHY deframer.
package xmit_phy_pkg;

  // Deframer states: between frames, waiting for a low nibble, waiting for a high nibble
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_e;

  localparam int LEN_W_DEF   = 12;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/xmit_ifg_timer.sv
// Idle-gap counter between frames. The counter saturates at IFG_MIN, and gap_ok_o
// is high once that many idle cycles have been seen. It comes out of reset already
// saturated, so the first frame after reset never reports a gap violation.
module xmit_ifg_timer #(
  parameter int IFG_MIN = 12
) (
  input  logic clk_phy,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic gap_ok_o
);

  localparam int CW = (IFG_MIN > 0) ? $clog2(IFG_MIN + 1) : 1;
  localparam logic [CW-1:0] SAT = CW'(IFG_MIN);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on frame end, otherwise count idle cycles up to saturation
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q < SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Gap counter register; reset value means "gap already satisfied"
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= SAT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign gap_ok_o = (cnt_q >= SAT);

endmodule

// File: rtl/xmit_phy_deframer.sv
// Receive-side deframer for the 4-bit transmit PHY stream: rebuilds bytes
// (low nibble first), delimits frames on phy_tx_en, and reports length,
// error flags and a running frame count. All outputs are registered.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | tx_en low between frames; idle-gap timer counting
//   ST_LO   | inside a frame, next nibble is a low half of a byte
//   ST_HI   | inside a frame, low half held, next nibble completes byte
module xmit_phy_deframer
  import xmit_phy_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MIN_LEN = 4,
  parameter int MAX_LEN = 2047,
  parameter int IFG_MIN = 12
) (
  input  logic                   clk_phy,
  input  logic                   reset_n,
  input  logic [3:0]             phy_data_in,
  input  logic                   phy_tx_en,
  output logic [7:0]             m_byte,
  output logic                   m_byte_valid,
  output logic                   m_sof,
  output logic                   m_eof,
  output logic [LEN_W-1:0]       m_len,
  output logic                   m_err_odd,
  output logic                   m_err_len,
  output logic                   m_err_ifg,
  output logic [FRAME_CNT_W-1:0] m_frame_cnt
);

  state_e           state_q;
  logic [3:0]       lo_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic             ifg_err_q;
  logic             frame_end;
  logic             len_bad;
  logic             gap_ok;

  // A frame ends on the first low tx_en sample while inside a frame
  assign frame_end = (state_q != ST_IDLE) && !phy_tx_en;

  // Saturating byte count and legality of the final (saturated) length
  assign len_d   = (len_q == '1) ? len_q : len_q + 1'b1;
  assign len_bad = (len_q < LEN_W'(MIN_LEN)) || (len_q > LEN_W'(MAX_LEN));

  xmit_ifg_timer #(
    .IFG_MIN (IFG_MIN)
  ) u_ifg_timer (
    .clk_phy  (clk_phy),
    .reset_n  (reset_n),
    .clr_i    (frame_end),
    .en_i     ((state_q == ST_IDLE) && !phy_tx_en),
    .gap_ok_o (gap_ok)
  );

  // Deframer FSM with nibble latch, length counter and registered outputs
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      lo_q         <= '0;
      len_q        <= '0;
      ifg_err_q    <= 1'b0;
      m_byte       <= '0;
      m_byte_valid <= 1'b0;
      m_sof        <= 1'b0;
      m_eof        <= 1'b0;
      m_len        <= '0;
      m_err_odd    <= 1'b0;
      m_err_len    <= 1'b0;
      m_err_ifg    <= 1'b0;
      m_frame_cnt  <= '0;
    end else begin
      m_byte_valid <= 1'b0;
      m_sof        <= 1'b0;
      m_eof        <= 1'b0;
      m_err_odd    <= 1'b0;
      m_err_len    <= 1'b0;
      m_err_ifg    <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (phy_tx_en) begin
            lo_q      <= phy_data_in;
            len_q     <= '0;
            ifg_err_q <= !gap_ok;
            state_q   <= ST_HI;
          end
        end
        ST_HI: begin
          if (phy_tx_en) begin
            m_byte       <= {phy_data_in, lo_q};
            m_byte_valid <= 1'b1;
            // length never returns to zero inside a frame, so zero marks the first byte
            m_sof        <= (len_q == '0);
            len_q        <= len_d;
            state_q      <= ST_LO;
          end
        end
        ST_LO: begin
          if (phy_tx_en) begin
            lo_q    <= phy_data_in;
            state_q <= ST_HI;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Frame termination: report and return to idle; a held half byte is dropped
      if (frame_end) begin
        m_eof       <= 1'b1;
        m_len       <= len_q;
        m_err_odd   <= (state_q == ST_HI);
        m_err_len   <= len_bad;
        m_err_ifg   <= ifg_err_q;
        m_frame_cnt <= m_frame_cnt + 1'b1;
        state_q     <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_xmit_phy_deframer.sv
// Directed bench for xmit_phy_deframer. Idle gaps are expressed as the number of
// low tx_en cycles after the cycle that ends the frame (end_idle(n) drives n+1 lows).
module tb_xmit_phy_deframer;

  logic        clk_phy = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  phy_data_in = 4'h0;
  logic        phy_tx_en = 1'b0;
  logic [7:0]  m_byte;
  logic        m_byte_valid;
  logic        m_sof;
  logic        m_eof;
  logic [11:0] m_len;
  logic        m_err_odd;
  logic        m_err_len;
  logic        m_err_ifg;
  logic [15:0] m_frame_cnt;

  int checks = 0;
  int failures = 0;

  // monitor state (written only by the monitor process)
  logic [7:0] bytes_q[$];
  int sof_cnt = 0, sof_bad = 0, eof_cnt = 0, ifg_total = 0, stray = 0, frame_bytes = 0;
  int last_len = 0;
  logic last_odd = 1'b0, last_elen = 1'b0, last_ifg = 1'b0;

  xmit_phy_deframer #(
    .LEN_W(12), .MIN_LEN(4), .MAX_LEN(2047), .IFG_MIN(12)
  ) dut (
    .clk_phy     (clk_phy),
    .reset_n     (reset_n),
    .phy_data_in (phy_data_in),
    .phy_tx_en   (phy_tx_en),
    .m_byte      (m_byte),
    .m_byte_valid(m_byte_valid),
    .m_sof       (m_sof),
    .m_eof       (m_eof),
    .m_len       (m_len),
    .m_err_odd   (m_err_odd),
    .m_err_len   (m_err_len),
    .m_err_ifg   (m_err_ifg),
    .m_frame_cnt (m_frame_cnt)
  );

  always #5 clk_phy = ~clk_phy;

  always @(negedge clk_phy) begin
    if (!reset_n) begin
      frame_bytes = 0;
    end else begin
      if (m_byte_valid) begin
        bytes_q.push_back(m_byte);
        if (m_sof !== (frame_bytes == 0)) sof_bad++;
        if (m_sof) sof_cnt++;
        frame_bytes++;
      end else if (m_sof) begin
        sof_bad++;
      end
      if (m_eof) begin
        eof_cnt++;
        last_len  = int'(m_len);
        last_odd  = m_err_odd;
        last_elen = m_err_len;
        last_ifg  = m_err_ifg;
        if (m_err_ifg) ifg_total++;
        if (m_byte_valid) stray++;
        frame_bytes = 0;
      end else if (m_err_odd || m_err_len || m_err_ifg) begin
        stray++;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int mode, input int i, input int n);
    if (mode == 0) return (i < 4 || i >= n - 4) ? 8'h33 : 8'hFF;
    return 8'((i * 7 + 3) & 255);
  endfunction

  task automatic drive_nib(input logic en, input logic [3:0] d);
    phy_tx_en   = en;
    phy_data_in = d;
    @(posedge clk_phy);
    #1;
  endtask

  task automatic send_bytes(input int n, input int mode, input bit odd);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = exp_byte(mode, i, n);
      drive_nib(1'b1, b[3:0]);
      drive_nib(1'b1, b[7:4]);
    end
    if (odd) drive_nib(1'b1, 4'h5);
  endtask

  task automatic end_idle(input int n);
    repeat (n + 1) drive_nib(1'b0, 4'h0);
  endtask

  task automatic do_reset();
    phy_tx_en = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk_phy);
    #1;
    reset_n = 1'b1;
    end_idle(1);
  endtask

  task automatic test_reset();
    phy_tx_en = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk_phy);
    #1;
    checks++;
    if ({m_byte_valid, m_sof, m_eof, m_err_odd, m_err_len, m_err_ifg} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes: got %b expected 000000",
        {m_byte_valid, m_sof, m_eof, m_err_odd, m_err_len, m_err_ifg});
    end
    checks++;
    if (m_byte !== 8'h00 || m_len !== 12'd0) begin
      failures++; $display("FAIL reset_data: got byte=%0h len=%0d expected 0/0", m_byte, m_len);
    end
    checks++;
    if (m_frame_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_cnt: got %0d expected 0", m_frame_cnt);
    end
    reset_n = 1'b1;
    end_idle(2);
  endtask

  task automatic test_frame_512();
    int b0, e0, s0, nb, bad;
    b0 = bytes_q.size(); e0 = eof_cnt; s0 = sof_cnt;
    send_bytes(512, 0, 1'b0);
    end_idle(12);
    nb = bytes_q.size() - b0;
    checks++;
    if (nb != 512) begin
      failures++; $display("FAIL f512_count: got %0d expected 512", nb);
    end
    bad = 0;
    for (int i = 0; i < nb && i < 512; i++)
      if (bytes_q[b0 + i] !== exp_byte(0, i, 512)) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL f512_data: got %0d wrong bytes expected 0", bad);
    end
    checks++;
    if (sof_cnt - s0 != 1 || eof_cnt - e0 != 1) begin
      failures++; $display("FAIL f512_sof_eof: got sof=%0d eof=%0d expected 1/1", sof_cnt - s0, eof_cnt - e0);
    end
    checks++;
    if (last_len != 512) begin
      failures++; $display("FAIL f512_len: got %0d expected 512", last_len);
    end
    checks++;
    if ({last_odd, last_elen, last_ifg} !== 3'b000) begin
      failures++; $display("FAIL f512_flags: got %b expected 000", {last_odd, last_elen, last_ifg});
    end
    checks++;
    if (m_frame_cnt !== 16'd1) begin
      failures++; $display("FAIL f512_fcnt: got %0d expected 1", m_frame_cnt);
    end
  endtask

  task automatic test_ten_frames();
    int e0, i0, b0;
    do_reset();
    e0 = eof_cnt; i0 = ifg_total; b0 = bytes_q.size();
    for (int f = 0; f < 10; f++) begin
      send_bytes(512, 0, 1'b0);
      end_idle(12);
    end
    checks++;
    if (m_frame_cnt !== 16'd10) begin
      failures++; $display("FAIL ten_fcnt: got %0d expected 10", m_frame_cnt);
    end
    checks++;
    if (eof_cnt - e0 != 10 || ifg_total - i0 != 0) begin
      failures++; $display("FAIL ten_eof_ifg: got eof=%0d ifg=%0d expected 10/0", eof_cnt - e0, ifg_total - i0);
    end
    checks++;
    if (bytes_q.size() - b0 != 5120) begin
      failures++; $display("FAIL ten_bytes: got %0d expected 5120", bytes_q.size() - b0);
    end
  endtask

  task automatic test_odd();
    int b0;
    b0 = bytes_q.size();
    send_bytes(4, 1, 1'b1);
    end_idle(12);
    checks++;
    if (bytes_q.size() - b0 != 4 || last_len != 4) begin
      failures++; $display("FAIL odd_len: got bytes=%0d len=%0d expected 4/4", bytes_q.size() - b0, last_len);
    end
    checks++;
    if ({last_odd, last_elen, last_ifg} !== 3'b100) begin
      failures++; $display("FAIL odd_flags: got %b expected 100", {last_odd, last_elen, last_ifg});
    end
    // single nibble: nothing to count, odd and too short
    send_bytes(0, 1, 1'b1);
    end_idle(12);
    checks++;
    if (last_len != 0 || {last_odd, last_elen} !== 2'b11) begin
      failures++; $display("FAIL nibble_frame: got len=%0d odd/len=%b expected 0/11", last_len, {last_odd, last_elen});
    end
  endtask

  task automatic test_len_limits();
    send_bytes(3, 1, 1'b0);
    end_idle(12);
    checks++;
    if (last_len != 3 || {last_odd, last_elen} !== 2'b01) begin
      failures++; $display("FAIL len3: got len=%0d odd/len=%b expected 3/01", last_len, {last_odd, last_elen});
    end
    send_bytes(4, 1, 1'b0);
    end_idle(12);
    checks++;
    if (last_len != 4 || {last_odd, last_elen} !== 2'b00) begin
      failures++; $display("FAIL len4: got len=%0d odd/len=%b expected 4/00", last_len, {last_odd, last_elen});
    end
    send_bytes(2048, 1, 1'b0);
    end_idle(12);
    checks++;
    if (last_len != 2048 || {last_odd, last_elen} !== 2'b01) begin
      failures++; $display("FAIL len2048: got len=%0d odd/len=%b expected 2048/01", last_len, {last_odd, last_elen});
    end
  endtask

  task automatic test_ifg();
    int i0;
    do_reset();
    send_bytes(8, 1, 1'b0);
    end_idle(11);
    checks++;
    if (last_ifg !== 1'b0) begin
      failures++; $display("FAIL ifg_first: got %b expected 0", last_ifg);
    end
    i0 = ifg_total;
    send_bytes(8, 1, 1'b0);
    end_idle(12);
    checks++;
    if (last_ifg !== 1'b1) begin
      failures++; $display("FAIL ifg_gap11: got %b expected 1", last_ifg);
    end
    send_bytes(8, 1, 1'b0);   // after exactly 12 idle: legal
    end_idle(0);
    send_bytes(8, 1, 1'b0);   // back to back: violation
    end_idle(3);
    checks++;
    if (ifg_total - i0 != 2 || last_ifg !== 1'b1) begin
      failures++; $display("FAIL ifg_b2b: got ifg_frames=%0d last=%b expected 2/1", ifg_total - i0, last_ifg);
    end
    checks++;
    if (m_frame_cnt !== 16'd4 || stray != 0 || sof_bad != 0) begin
      failures++; $display("FAIL ifg_misc: got fcnt=%0d stray=%0d sof_bad=%0d expected 4/0/0", m_frame_cnt, stray, sof_bad);
    end
  endtask

  task automatic test_reset_midframe();
    int e0;
    e0 = eof_cnt;
    send_bytes(100, 1, 1'b0);
    phy_tx_en = 1'b0;
    reset_n   = 1'b0;
    #1;
    checks++;
    if (m_frame_cnt !== 16'd0 || m_byte_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async: got fcnt=%0d valid=%b expected 0/0", m_frame_cnt, m_byte_valid);
    end
    repeat (2) @(posedge clk_phy);
    #1;
    reset_n = 1'b1;
    end_idle(3);
    checks++;
    if (eof_cnt - e0 != 0 || m_frame_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_mid_noeof: got eof=%0d fcnt=%0d expected 0/0", eof_cnt - e0, m_frame_cnt);
    end
    send_bytes(64, 1, 1'b0);
    end_idle(3);
    checks++;
    if (last_len != 64 || m_frame_cnt !== 16'd1 || eof_cnt - e0 != 1) begin
      failures++; $display("FAIL rst_mid_next: got len=%0d fcnt=%0d eof=%0d expected 64/1/1", last_len, m_frame_cnt, eof_cnt - e0);
    end
    checks++;
    if ({last_odd, last_elen, last_ifg} !== 3'b000) begin
      failures++; $display("FAIL rst_mid_flags: got %b expected 000", {last_odd, last_elen, last_ifg});
    end
  endtask

  initial begin
    test_reset();
    test_frame_512();
    test_ten_frames();
    test_odd();
    test_len_limits();
    test_ifg();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xmit_phy_deframer.md
# xmit_phy_deframer

Receive-side checker/deframer sitting directly downstream of the transmit top level on the PHY clock domain. Consumes the 4-bit nibble stream and transmit-enable, reassembles bytes, delimits frames, and reports per-frame length, error flags and a running frame count. Used as the in-system loopback monitor and as the scoreboard front end for transmit benches.

## Interface
- LEN_W, 12: width of byte-length counter; saturates at 2**LEN_W-1
- MIN_LEN, 4: minimum legal frame length in bytes
- MAX_LEN, 2047: maximum legal frame length in bytes
- IFG_MIN, 12: minimum idle clk_phy cycles between frames
- clk_phy  in  1  PHY clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- phy_data_in  in  4  nibble from transmitter, low nibble of each byte first
- phy_tx_en  in  1  high for every nibble of a frame; frame = contiguous high run
- m_byte  out  8  reassembled byte
- m_byte_valid  out  1  one-cycle strobe per complete byte
- m_sof  out  1  high with m_byte_valid on first byte of frame
- m_eof  out  1  one-cycle end-of-frame pulse (not coincident with a byte)
- m_len  out  LEN_W  byte count of frame, valid with m_eof
- m_err_odd  out  1  frame ended on half byte, valid with m_eof
- m_err_len  out  1  length < MIN_LEN or > MAX_LEN, valid with m_eof
- m_err_ifg  out  1  frame began before IFG_MIN idle cycles elapsed, valid with m_eof
- m_frame_cnt  out  16  frames completed since reset, wraps

## Operation
- States: IDLE (tx_en low, gap counting), LO (expecting low nibble), HI (expecting high nibble).
- IDLE: tx_en=1 -> capture nibble as low half, latch ifg flag, clear length, go HI.
- HI: tx_en=1 -> form byte {nibble, lo}, strobe m_byte_valid, length+1 (saturating), go LO; tx_en=0 -> odd error, partial byte discarded, end frame, go IDLE.
- LO: tx_en=1 -> capture low nibble, go HI; tx_en=0 -> end frame, go IDLE.
- End frame: pulse m_eof with m_len, error flags; m_frame_cnt+1 (wraps 0xFFFF->0).
- m_sof asserted only on the first m_byte_valid of a frame.
- Gap counter: clears on end frame, increments in IDLE, saturates at IFG_MIN. IFG check disabled for first frame after reset (counter resets to IFG_MIN).
- m_err_len uses final saturated length; zero-byte frame (single nibble) gives len=0, err_odd=1, err_len=1.

## Timing
- All outputs registered; reset values: m_byte=0, all strobes/flags 0, m_len=0, m_frame_cnt=0, state IDLE.
- Low nibble sampled cycle t, high nibble t+1, m_byte_valid at t+2 (latency 2 from low nibble).
- Falling tx_en sampled low at cycle e -> m_eof, m_len, flags valid at e+1 for exactly one cycle; flags 0 outside m_eof.
- New frame may start the cycle tx_en is first sampled low after end (0-idle); it flags m_err_ifg if IFG_MIN>0.
- Gap of exactly IFG_MIN idle cycles is legal; IFG_MIN-1 is a violation.
- reset_n low mid-frame: immediate return to IDLE, no m_eof for the aborted frame, counts cleared.

## Structure
- Package xmit_phy_pkg: state enum (IDLE, LO, HI), default LEN_W, frame-count width constant.
- Sub-module xmit_ifg_timer: saturating idle-gap counter with clear/enable and "gap_ok" output.
- Top holds FSM, nibble latch, length counter, output registers.

## Test plan
- 512-byte frame: bytes 0x33 x4, 0xFF x504, 0x33 x4 sent low nibble first -> 512 m_byte_valid, m_sof on first 0x33, m_eof with m_len=512, no errors, m_frame_cnt=1.
- 10 such frames with 12 idle cycles between -> m_frame_cnt=10, no m_err_ifg on any frame.
- 9-nibble frame -> 4 bytes out, m_len=4, m_err_odd=1, m_err_len=0.
- 3-byte frame -> m_len=3, m_err_len=1; 2048-byte frame -> m_len=2048, m_err_len=1.
- Second frame after 11 idle cycles -> its m_eof carries m_err_ifg=1; first frame after reset never flags it.
- reset_n pulsed low after 100 bytes of a frame -> no m_eof, m_frame_cnt=0, next full frame reports m_len correctly and m_frame_cnt=1.
